// File: rtl/compare_window_filt.sv
// Multi-channel signed window comparator with a consecutive-sample filter and sticky fault latches.
// Optional first-fault capture is built when COMPARE_FIRST_FAULT_EN is defined.
module compare_window_filt #(
    parameter int WIDTH  = 16,
    parameter int CH     = 4,
    parameter int FILTER = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              sample_i,
    input  logic [CH*WIDTH-1:0]               value_i,
    input  logic [CH*2*WIDTH-1:0]             limits_i,
    input  logic [CH-1:0]                     mask_i,
    input  logic                              clear_i,
    output logic [2*CH-1:0]                   compare_o,
    output logic [2*CH-1:0]                   fault_o,
    output logic                              fault_any_o,
    output logic [((CH > 1) ? $clog2(CH) : 1):0] first_fault_o,
    output logic                              first_valid_o
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam int NB = 2 * CH;
    localparam int CW = $clog2(FILTER + 1);

    logic [NB-1:0] cond;
    logic [NB-1:0] hit;
    logic [NB-1:0] compare_q;
    logic [NB-1:0] fault_q;
    logic [NB-1:0] fault_d;
    logic          any_q;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];

    always_comb begin
        logic signed [WIDTH-1:0] v;
        logic signed [WIDTH-1:0] h;
        logic signed [WIDTH-1:0] l;
        cond = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            v = value_i[k*WIDTH +: WIDTH];
            h = limits_i[k*2*WIDTH +: WIDTH];
            l = limits_i[k*2*WIDTH+WIDTH +: WIDTH];
            cond[2*k]   = (v > h);
            cond[2*k+1] = (v < l);
        end
    end

    // Clear wins over a simultaneous sample: that sample is not counted.
    always_comb begin
        hit = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            cnt_d[j] = cnt_q[j];
            if (clear_i) begin
                cnt_d[j] = '0;
            end else if (sample_i) begin
                if (cond[j] && !mask_i[j>>1])
                    cnt_d[j] = (cnt_q[j] == CW'(FILTER)) ? cnt_q[j] : cnt_q[j] + CW'(1);
                else
                    cnt_d[j] = '0;
                hit[j] = (cnt_d[j] == CW'(FILTER));
            end
        end
        fault_d = clear_i ? '0 : (fault_q | hit);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            compare_q <= '0;
            fault_q   <= '0;
            any_q     <= 1'b0;
            for (int unsigned j = 0; j < NB; j++)
                cnt_q[j] <= '0;
        end else begin
            if (sample_i)
                compare_q <= cond;
            fault_q <= fault_d;
            any_q   <= |fault_d;
            for (int unsigned j = 0; j < NB; j++)
                cnt_q[j] <= cnt_d[j];
        end
    end

    assign compare_o   = compare_q;
    assign fault_o     = fault_q;
    assign fault_any_o = any_q;

`ifdef COMPARE_FIRST_FAULT_EN
    logic [NB-1:0] newly;
    logic [IW:0]   first_sel;
    logic [IW:0]   first_q;
    logic          valid_q;

    // Lowest newly latched bit wins: lower channel first, H before L.
    always_comb begin
        logic found;
        newly     = fault_d & ~fault_q;
        first_sel = '0;
        found     = 1'b0;
        for (int unsigned j = 0; j < NB; j++) begin
            if (newly[j] && !found) begin
                found     = 1'b1;
                first_sel = {j[0], IW'(j >> 1)};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            first_q <= '0;
            valid_q <= 1'b0;
        end else if (!valid_q && (|newly)) begin
            first_q <= first_sel;
            valid_q <= 1'b1;
        end
    end

    assign first_fault_o = first_q;
    assign first_valid_o = valid_q;
`else
    assign first_fault_o = '0;
    assign first_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_compare_window_filt.sv
// Directed self-checking bench for compare_window_filt (CH=4, WIDTH=16, FILTER=3).
module tb_compare_window_filt;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        sample_i;
    logic [63:0] value_i;
    logic [127:0] limits_i;
    logic [3:0]  mask_i;
    logic        clear_i;
    logic [7:0]  compare_o;
    logic [7:0]  fault_o;
    logic        fault_any_o;
    logic [2:0]  first_fault_o;
    logic        first_valid_o;

    logic signed [15:0] val [4];
    logic signed [15:0] hi  [4];
    logic signed [15:0] lo  [4];

    int checks = 0;
    int errors = 0;

    compare_window_filt #(.WIDTH(16), .CH(4), .FILTER(3)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sample_i      (sample_i),
        .value_i       (value_i),
        .limits_i      (limits_i),
        .mask_i        (mask_i),
        .clear_i       (clear_i),
        .compare_o     (compare_o),
        .fault_o       (fault_o),
        .fault_any_o   (fault_any_o),
        .first_fault_o (first_fault_o),
        .first_valid_o (first_valid_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            value_i[k*16 +: 16]     = val[k];
            limits_i[k*32 +: 16]    = hi[k];
            limits_i[k*32+16 +: 16] = lo[k];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic defaults();
        for (int k = 0; k < 4; k++) begin
            val[k] = 16'sd0;
            hi[k]  = 16'sd1000;
            lo[k]  = -16'sd1000;
        end
        mask_i   = 4'b0000;
        clear_i  = 1'b0;
        sample_i = 1'b0;
    endtask

    task automatic do_reset();
        defaults();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic step(input logic s);
        sample_i = s;
        tick();
        sample_i = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            val[k] = 16'($urandom);
            hi[k]  = 16'($urandom);
            lo[k]  = 16'($urandom);
        end
        mask_i   = 4'($urandom);
        clear_i  = 1'($urandom);
        sample_i = 1'b1;
        reset_i  = 1'b1;
        tick();
        checks++;
        if ({compare_o, fault_o, fault_any_o, first_fault_o, first_valid_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: got cmp=%h flt=%h any=%b ff=%h fv=%b, expected all 0",
                     compare_o, fault_o, fault_any_o, first_fault_o, first_valid_o);
        end
        reset_i  = 1'b0;
        sample_i = 1'b0;
        clear_i  = 1'b0;
        tick();
        tick();
        checks++;
        if ({compare_o, fault_o, fault_any_o, first_fault_o, first_valid_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got cmp=%h flt=%h any=%b, expected all 0",
                     compare_o, fault_o, fault_any_o);
        end
    endtask

    task automatic test_filter();
        do_reset();
        val[0] = 16'sd100; hi[0] = 16'sd50; lo[0] = -16'sd50;
        step(1'b1);
        checks++;
        if (compare_o !== 8'h01 || fault_o !== 8'h00) begin
            errors++;
            $display("FAIL filter_s1: got cmp=%h flt=%h, expected cmp=01 flt=00", compare_o, fault_o);
        end
        step(1'b0);
        step(1'b1);
        checks++;
        if (compare_o !== 8'h01 || fault_o !== 8'h00 || fault_any_o !== 1'b0) begin
            errors++;
            $display("FAIL filter_s2_idle_gap: got cmp=%h flt=%h any=%b, expected 01 00 0",
                     compare_o, fault_o, fault_any_o);
        end
        step(1'b0);
        step(1'b0);
        step(1'b1);
        checks++;
        if (fault_o !== 8'h01 || fault_any_o !== 1'b1) begin
            errors++;
            $display("FAIL filter_s3_latch: got flt=%h any=%b, expected 01 1", fault_o, fault_any_o);
        end
        val[0] = 16'sd10;
        step(1'b1);
        checks++;
        if (compare_o !== 8'h00 || fault_o !== 8'h01 || fault_any_o !== 1'b1) begin
            errors++;
            $display("FAIL filter_sticky: got cmp=%h flt=%h any=%b, expected 00 01 1",
                     compare_o, fault_o, fault_any_o);
        end
`ifndef COMPARE_FIRST_FAULT_EN
        checks++;
        if (first_fault_o !== 3'd0 || first_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_disabled: got ff=%h fv=%b, expected 0 0", first_fault_o, first_valid_o);
        end
`endif
    endtask

    task automatic test_signed();
        logic [7:0] exp_f;
        do_reset();
        val[1] = -16'sd100; hi[1] = 16'sd50; lo[1] = -16'sd50;
        step(1'b1);
        checks++;
        if (compare_o !== 8'h08) begin
            errors++;
            $display("FAIL signed_cmp: got cmp=%h, expected 08", compare_o);
        end
        step(1'b1);
        val[1] = 16'sd0;
        step(1'b1);
        val[1] = -16'sd100;
        step(1'b1);
        step(1'b1);
        exp_f = 8'h00;
        checks++;
        if (fault_o !== exp_f || compare_o !== 8'h08) begin
            errors++;
            $display("FAIL signed_broken_run: got flt=%h cmp=%h, expected flt=%h cmp=08",
                     fault_o, compare_o, exp_f);
        end
    endtask

    task automatic test_mask();
        do_reset();
        val[2] = 16'sd200; hi[2] = 16'sd50;
        mask_i = 4'b0100;
        for (int i = 0; i < 5; i++) step(1'b1);
        checks++;
        if (compare_o !== 8'h10 || fault_o !== 8'h00) begin
            errors++;
            $display("FAIL mask_blocks: got cmp=%h flt=%h, expected 10 00", compare_o, fault_o);
        end
        mask_i = 4'b0000;
        step(1'b1);
        step(1'b1);
        checks++;
        if (fault_o !== 8'h00) begin
            errors++;
            $display("FAIL unmask_two: got flt=%h, expected 00", fault_o);
        end
        step(1'b1);
        checks++;
        if (fault_o !== 8'h10 || fault_any_o !== 1'b1) begin
            errors++;
            $display("FAIL unmask_three: got flt=%h any=%b, expected 10 1", fault_o, fault_any_o);
        end
        mask_i = 4'b0100;
        step(1'b1);
        checks++;
        if (fault_o !== 8'h10) begin
            errors++;
            $display("FAIL mask_after_fault: got flt=%h, expected 10", fault_o);
        end
    endtask

    task automatic test_clear();
        do_reset();
        val[0] = 16'sd100; hi[0] = 16'sd50; lo[0] = -16'sd50;
        step(1'b1);
        step(1'b1);
        clear_i = 1'b1;
        step(1'b1);
        clear_i = 1'b0;
        checks++;
        if (fault_o !== 8'h00 || compare_o !== 8'h01) begin
            errors++;
            $display("FAIL clear_with_sample: got flt=%h cmp=%h, expected 00 01", fault_o, compare_o);
        end
        step(1'b1);
        step(1'b1);
        checks++;
        if (fault_o !== 8'h00) begin
            errors++;
            $display("FAIL clear_sample5: got flt=%h, expected 00", fault_o);
        end
        step(1'b1);
        checks++;
        if (fault_o !== 8'h01 || fault_any_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_sample6: got flt=%h any=%b, expected 01 1", fault_o, fault_any_o);
        end
        clear_i = 1'b1;
        step(1'b0);
        clear_i = 1'b0;
        checks++;
        if (fault_o !== 8'h00 || fault_any_o !== 1'b0 || compare_o !== 8'h01) begin
            errors++;
            $display("FAIL clear_idle: got flt=%h any=%b cmp=%h, expected 00 0 01",
                     fault_o, fault_any_o, compare_o);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        val[0] = 16'sd50; hi[0] = 16'sd50; lo[0] = -16'sd50;
        val[1] = -16'sd50; hi[1] = 16'sd50; lo[1] = -16'sd50;
        step(1'b1);
        checks++;
        if (compare_o !== 8'h00) begin
            errors++;
            $display("FAIL boundary_equal: got cmp=%h, expected 00", compare_o);
        end
        val[0] = 16'sd51;
        val[1] = -16'sd51;
        step(1'b1);
        checks++;
        if (compare_o !== 8'h09) begin
            errors++;
            $display("FAIL boundary_plus1: got cmp=%h, expected 09", compare_o);
        end
        do_reset();
        val[3] = 16'sd0; hi[3] = -16'sd10; lo[3] = 16'sd10;
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (compare_o !== 8'hC0 || fault_o !== 8'hC0) begin
            errors++;
            $display("FAIL misconfig_both: got cmp=%h flt=%h, expected C0 C0", compare_o, fault_o);
        end
    endtask

`ifdef COMPARE_FIRST_FAULT_EN
    task automatic test_first_fault();
        do_reset();
        val[1] = 16'sd100;  hi[1] = 16'sd50; lo[1] = -16'sd50;
        val[3] = -16'sd100; hi[3] = 16'sd50; lo[3] = -16'sd50;
        step(1'b1);
        step(1'b1);
        checks++;
        if (first_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_early: got fv=%b, expected 0", first_valid_o);
        end
        step(1'b1);
        checks++;
        if (fault_o !== 8'h84 || first_fault_o !== 3'b001 || first_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL first_capture: got flt=%h ff=%b fv=%b, expected 84 001 1",
                     fault_o, first_fault_o, first_valid_o);
        end
        val[0] = 16'sd100; hi[0] = 16'sd50; lo[0] = -16'sd50;
        for (int i = 0; i < 3; i++) step(1'b1);
        checks++;
        if (fault_o !== 8'h85 || first_fault_o !== 3'b001 || first_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL first_hold: got flt=%h ff=%b fv=%b, expected 85 001 1",
                     fault_o, first_fault_o, first_valid_o);
        end
        clear_i = 1'b1;
        step(1'b0);
        clear_i = 1'b0;
        checks++;
        if (first_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_clear: got fv=%b, expected 0", first_valid_o);
        end
    endtask
`endif

    initial begin
        defaults();
        reset_i = 1'b0;
        test_reset();
        test_filter();
        test_signed();
        test_mask();
        test_clear();
        test_boundary();
`ifdef COMPARE_FIRST_FAULT_EN
        test_first_fault();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
